pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage core. It gathers stall requests from ID, EX and MEM and the exception/flush request from MEM, then drives the per-stage stall vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb. It also sequences a one-cycle pipeline flush with a redirect PC, and keeps a stall-cycle performance counter. When compiled in, a stall watchdog forces recovery from a hung stall.

---
 rtl/pipe_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencing controller for the five-stage core.
// Merges ID/EX/MEM stall requests and the MEM flush request into a per-stage
// stall vector. Sequences a one-cycle registered flush with a redirect PC and
// keeps a saturating stall-cycle counter.
// Optional stall watchdog: define PIPE_CTRL_WDOG_EN to build it.
module pipe_ctrl #(
    parameter int unsigned WDOG_LIMIT  = 255,
    parameter logic [31:0] WDOG_VECTOR = 32'h0000_0040
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        flush_req,
    input  logic [31:0] flush_pc,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic [31:0] stall_cnt,
    output logic        wdog_fired
);

    localparam logic [1:0] StRun   = 2'd0;
    localparam logic [1:0] StStall = 2'd1;
    localparam logic [1:0] StFlush = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        flush_q, flush_d;
    logic [31:0] new_pc_q, new_pc_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    logic        req_any;
    logic        wdog_fire;
    logic        flush_any;
    logic [31:0] redirect_pc;

    assign req_any = stallreq_id | stallreq_ex | stallreq_mem;

`ifdef PIPE_CTRL_WDOG_EN
    logic [31:0] wdog_cnt_q, wdog_cnt_d;
    logic        wdog_fired_q, wdog_fired_d;

    // Fire once the stall has persisted WDOG_LIMIT counted cycles with a request still up.
    always_comb begin
        wdog_fire    = (state_q == StStall) && req_any && (wdog_cnt_q == WDOG_LIMIT);
        wdog_cnt_d   = '0;
        if ((state_q == StStall) && !wdog_fire) begin
            wdog_cnt_d = wdog_cnt_q + 32'd1;
        end
        wdog_fired_d = wdog_fired_q | wdog_fire;
    end

    // Watchdog counter and sticky fired flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt_q   <= '0;
            wdog_fired_q <= 1'b0;
        end else begin
            wdog_cnt_q   <= wdog_cnt_d;
            wdog_fired_q <= wdog_fired_d;
        end
    end

    // A real flush request overrides the watchdog target.
    assign redirect_pc = flush_req ? flush_pc : WDOG_VECTOR;
    assign wdog_fired  = wdog_fired_q;
`else
    logic unused_params;

    assign wdog_fire     = 1'b0;
    assign redirect_pc   = flush_pc;
    assign wdog_fired    = 1'b0;
    assign unused_params = ^{WDOG_LIMIT, WDOG_VECTOR};
`endif

    assign flush_any = flush_req | wdog_fire;

    // Zero-latency stall vector; deeper requests freeze more upstream stages.
    always_comb begin
        stall = 6'b000000;
        if (!rst && (state_q != StFlush)) begin
            if (flush_any) begin
                stall = 6'b111111;
            end else if (stallreq_mem) begin
                stall = 6'b011111;
            end else if (stallreq_ex) begin
                stall = 6'b001111;
            end else if (stallreq_id) begin
                stall = 6'b000111;
            end
        end
    end

    // Next-state, flush strobe and redirect PC; FLUSH ignores all stale requests.
    always_comb begin
        state_d  = state_q;
        flush_d  = 1'b0;
        new_pc_d = new_pc_q;
        case (state_q)
            StRun, StStall: begin
                if (flush_any) begin
                    state_d  = StFlush;
                    flush_d  = 1'b1;
                    new_pc_d = redirect_pc;
                end else if (req_any) begin
                    state_d = StStall;
                end else begin
                    state_d = StRun;
                end
            end
            StFlush: state_d = StRun;
            default: state_d = StRun;
        endcase
    end

    // Saturating count of cycles in which the PC is held.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall[0] && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Controller state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            flush_q     <= 1'b0;
            new_pc_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_q     <= flush_d;
            new_pc_q    <= new_pc_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign flush     = flush_q;
    assign new_pc    = new_pc_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed stimulus for pipe_ctrl with a behavioural model checked
// every cycle on the falling edge, plus pinned literal expectations per cycle.
module tb_pipe_ctrl;

    localparam int unsigned Limit = 4;
    localparam logic [31:0] Vec   = 32'h0000_0040;
`ifdef PIPE_CTRL_WDOG_EN
    localparam bit WdEn = 1'b1;
`else
    localparam bit WdEn = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic        flush_req;
    logic [31:0] flush_pc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] stall_cnt;
    logic        wdog_fired;

    pipe_ctrl #(
        .WDOG_LIMIT  (Limit),
        .WDOG_VECTOR (Vec)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .flush_req    (flush_req),
        .flush_pc     (flush_pc),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .stall_cnt    (stall_cnt),
        .wdog_fired   (wdog_fired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Pinned literal expectations: 0 stall, 1 flush, 2 new_pc, 3 stall_cnt, 4 wdog_fired.
    bit          pin_en [5];
    logic [31:0] pin_v  [5];
    bit          preload_req;

    // Model state: what the outputs must be after the coming rising edge.
    bit          m_valid = 1'b0;
    bit          m_flushing;
    bit          m_stalled;
    logic [31:0] m_new_pc;
    logic [31:0] m_cnt;
    int unsigned m_wd;
    bit          m_wfired;

    function automatic logic [5:0] held_mask(int n);
        held_mask = 6'((1 << n) - 1);
    endfunction

    task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process and model update, once per cycle on the falling edge.
    always @(negedge clk) begin : model
        logic [5:0]  exp_stall;
        logic [31:0] act [5];
        string       nm  [5];
        int          depth;
        bit          req_any;
        bit          fire;

        nm[0] = "stall"; nm[1] = "flush"; nm[2] = "new_pc";
        nm[3] = "stall_cnt"; nm[4] = "wdog_fired";
        act[0] = 32'(stall); act[1] = 32'(flush); act[2] = new_pc;
        act[3] = stall_cnt; act[4] = 32'(wdog_fired);

        if (preload_req) m_cnt = 32'hFFFF_FFFE;
        req_any = stallreq_id | stallreq_ex | stallreq_mem;
        fire = WdEn && !rst && !m_flushing && m_stalled && (m_wd == Limit) && req_any;

        // Number of held stages, counted from the PC end.
        if (rst || m_flushing)          depth = 0;
        else if (flush_req || fire)     depth = 6;
        else if (stallreq_mem)          depth = 5;
        else if (stallreq_ex)           depth = 4;
        else if (stallreq_id)           depth = 3;
        else                            depth = 0;
        exp_stall = held_mask(depth);

        if (m_valid) begin
            cmp("model_stall", act[0], 32'(exp_stall));
            cmp("model_flush", act[1], 32'(m_flushing));
            cmp("model_new_pc", act[2], m_new_pc);
            cmp("model_stall_cnt", act[3], m_cnt);
            cmp("model_wdog_fired", act[4], 32'(m_wfired));
        end
        for (int k = 0; k < 5; k++) begin
            if (pin_en[k]) cmp({"pin_", nm[k]}, act[k], pin_v[k]);
        end

        if (rst) begin
            m_valid = 1'b1; m_flushing = 1'b0; m_stalled = 1'b0;
            m_new_pc = '0; m_cnt = '0; m_wd = 0; m_wfired = 1'b0;
        end else if (m_flushing) begin
            m_flushing = 1'b0; m_stalled = 1'b0; m_wd = 0;
        end else begin
            if (exp_stall[0] && (m_cnt != 32'hFFFF_FFFF)) m_cnt = m_cnt + 32'd1;
            if (flush_req || fire) begin
                m_flushing = 1'b1;
                m_new_pc   = flush_req ? flush_pc : Vec;
                if (fire) m_wfired = 1'b1;
                m_stalled  = 1'b0;
                m_wd       = 0;
            end else begin
                m_wd      = m_stalled ? m_wd + 1 : 0;
                m_stalled = req_any;
            end
        end
    end

    task automatic pin(int k, logic [31:0] v);
        pin_en[k] = 1'b1;
        pin_v[k]  = v;
    endtask

    // Finish the current cycle: let the falling-edge checks run, then cross the edge.
    task automatic cyc();
        @(negedge clk);
        #1;
        for (int k = 0; k < 5; k++) pin_en[k] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        stallreq_id = 1'b0; stallreq_ex = 1'b0; stallreq_mem = 1'b0;
        flush_req = 1'b0; flush_pc = '0;
    endtask

    task automatic do_reset();
        clear_reqs();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 5; k++) pin_en[k] = 1'b0;
        preload_req = 1'b0;
        clear_reqs();
        rst = 1'b1;
        stallreq_mem = 1'b1;
        @(posedge clk);
        #1;

        // Reset held for two cycles with a pending MEM stall.
        for (int i = 0; i < 2; i++) begin
            pin(0, 0); pin(1, 0); pin(2, 0); pin(3, 0); pin(4, 0);
            cyc();
        end
        rst = 1'b0;
        pin(0, 32'h1F);
        cyc();
        stallreq_mem = 1'b0;
        cyc();

        // Priority ladder and counter.
        do_reset();
        stallreq_id = 1'b1; pin(0, 32'h07); cyc();
        stallreq_ex = 1'b1; pin(0, 32'h0F); cyc();
        stallreq_mem = 1'b1; pin(0, 32'h1F); cyc();
        clear_reqs(); pin(0, 0); pin(3, 3); cyc();

        // Flush in the middle of an EX stall.
        do_reset();
        stallreq_ex = 1'b1;
        cyc();
        cyc();
        flush_req = 1'b1; flush_pc = 32'h8000_0180; pin(0, 32'h3F); cyc();
        flush_req = 1'b0; flush_pc = '0;
        pin(0, 0); pin(1, 1); pin(2, 32'h8000_0180); cyc();
        pin(0, 32'h0F); pin(1, 0); pin(2, 32'h8000_0180); pin(3, 3); cyc();
        clear_reqs();
        cyc();

        // Back-to-back flush pulses: second one lands in FLUSH and is dropped.
        flush_req = 1'b1; flush_pc = 32'h1234_5678; pin(0, 32'h3F); cyc();
        flush_req = 1'b1; flush_pc = 32'hDEAD_BEE0; pin(0, 0); pin(1, 1); pin(2, 32'h1234_5678);
        cyc();
        clear_reqs(); pin(1, 0); pin(2, 32'h1234_5678); cyc();

        // Reset while in FLUSH, then reset in the middle of a stall.
        flush_req = 1'b1; flush_pc = 32'hCAFE_0000; cyc();
        flush_req = 1'b0; rst = 1'b1; pin(1, 1); pin(0, 0); cyc();
        rst = 1'b0; pin(1, 0); pin(2, 0); pin(3, 0); cyc();
        stallreq_mem = 1'b1;
        cyc();
        cyc();
        rst = 1'b1; pin(0, 0); cyc();
        rst = 1'b0; pin(0, 32'h1F); pin(3, 0); cyc();
        clear_reqs();
        cyc();

        // Counter saturation from a preloaded value.
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        preload_req = 1'b1;
        @(negedge clk);
        #1;
        release dut.stall_cnt_q;
        preload_req = 1'b0;
        @(posedge clk);
        #1;
        stallreq_id = 1'b1; pin(3, 32'hFFFF_FFFE); cyc();
        pin(3, 32'hFFFF_FFFF); cyc();
        pin(3, 32'hFFFF_FFFF); cyc();
        clear_reqs(); pin(3, 32'hFFFF_FFFF); cyc();

        // Hung MEM stall.
        do_reset();
        stallreq_mem = 1'b1;
`ifdef PIPE_CTRL_WDOG_EN
        for (int i = 0; i < 5; i++) begin
            pin(0, 32'h1F); pin(1, 0); pin(4, 0);
            cyc();
        end
        pin(0, 32'h3F); pin(4, 0); cyc();
        pin(0, 0); pin(1, 1); pin(2, Vec); pin(4, 1); cyc();
        pin(0, 32'h1F); pin(1, 0); pin(4, 1); cyc();
        cyc();
        clear_reqs(); pin(4, 1); cyc();
        do_reset();
        pin(4, 0); cyc();
`else
        for (int i = 0; i < 100; i++) begin
            pin(0, 32'h1F); pin(1, 0); pin(4, 0);
            cyc();
        end
        clear_reqs(); pin(0, 0); pin(1, 0); cyc();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
